stat_probe_engine: RTL and testbench
====================================

STAT_PROBE_ENGINE -- requirements
Module: stat_probe_engine

Interface
REQ-001 Parameter N_IN, default 32: width of the primary data inputs driven into the locked circuit under test.
REQ-002 Parameter N_KEY, default 128: width of the key vector.
REQ-003 Parameter N_OUT, default 22: number of circuit outputs observed.
REQ-004 Parameter N_PAT, default 256, range 1..65535: number of input patterns per run.
REQ-005 Parameter SETTLE_CYC, default 2, minimum 0: wait cycles between applying a pattern and sampling it.
REQ-006 v_in1_v  in  1: the single clock; all logic on its rising edge.
REQ-007 reset  in  1: synchronous, active-low reset.
REQ-008 start  in  1: single-cycle request to begin a run; honoured only in IDLE.
REQ-009 abort  in  1: cancels a run from any state.
REQ-010 key_in  in  N_KEY: key captured on an accepted start.
REQ-011 seed_in  in  N_IN: LFSR seed captured on an accepted start.
REQ-012 dut_in  out  N_IN: pattern driven to the circuit under test.
REQ-013 dut_key  out  N_KEY: captured key driven to the circuit under test.
REQ-014 dut_out  in  N_OUT: circuit-under-test outputs.
REQ-015 busy  out  1: high in every state except IDLE.
REQ-016 res_valid / res_ready  out / in  1: result stream handshake.
REQ-017 res_idx  out  clog2(N_OUT): output-bit index of the current result.
REQ-018 res_count  out  CNT_W = clog2(N_PAT+1): ones-count for output bit res_idx.
REQ-019 done  out  1: one-cycle pulse when a run completes normally.

Function
REQ-020 FSM states: IDLE, APPLY, SETTLE, SAMPLE, DRAIN, DONE.
REQ-021 IDLE + start: capture key_in and seed_in, clear all counters, go to APPLY. A zero seed is replaced with 1.
REQ-022 APPLY, 1 cycle: dut_in = current LFSR state; then SETTLE, or straight to SAMPLE if SETTLE_CYC = 0.
REQ-023 SETTLE: hold dut_in for exactly SETTLE_CYC cycles, then SAMPLE.
REQ-024 SAMPLE, 1 cycle: for each bit i, cnt[i] += dut_out[i]; advance the LFSR one step; increment the pattern count.
REQ-025 After SAMPLE: go to APPLY if pattern count < N_PAT; otherwise go to DRAIN with idx = 0.
REQ-026 Cycles per pattern = 2 + SETTLE_CYC.
REQ-027 LFSR: maximal-length Galois form of width N_IN, with taps from the package table.
REQ-028 Counters are CNT_W wide and cannot overflow, since each bit reaches at most N_PAT.
REQ-029 DRAIN: res_valid = 1, res_idx = idx, res_count = cnt[idx].
REQ-030 DRAIN, res_ready = 1: idx increments. After idx = N_OUT-1 is accepted, go to DONE.
REQ-031 DRAIN, res_ready = 0: res_idx and res_count stay stable.
REQ-032 DONE: done = 1 for one cycle, then IDLE.
REQ-033 dut_key holds the captured key from start until the next accepted start, including while in IDLE.
REQ-034 start outside IDLE is ignored.
REQ-035 abort in any non-IDLE state returns the FSM to IDLE next cycle.
REQ-036 On abort: no done pulse, res_valid drops, counters are left stale (cleared by the next start).
REQ-037 abort and start in the same cycle in IDLE: abort wins and start is ignored.

Reset
REQ-038 Reset low at a clock edge forces: state IDLE, dut_in 0, dut_key 0, busy 0, res_valid 0, done 0, res_idx 0, res_count 0, all counters 0, LFSR 1.
REQ-039 Reset applies mid-run, overriding every other input.

Structure
REQ-040 Package stat_probe_pkg holds the state enumeration, the LFSR tap table indexed by width, and the clog2-based CNT_W helper.
REQ-041 Sub-module stat_probe_lfsr (parametrised width, load, step enable) holds the pattern generator; all other logic is in stat_probe_engine.

Verification
Bench configuration: N_IN=4, N_KEY=4, N_OUT=2, N_PAT=8, SETTLE_CYC=1, with a behavioural model as the circuit under test.
REQ-042 Model out0 = 1, out1 = 0; start with seed 0 -> first dut_in = 4'b0001; stream gives (0, 8), (1, 0); done pulses 24 cycles + drain after start.
REQ-043 Model out = {key[0], in[0]}, key = 4'b0001 -> res_count[1] = 8; res_count[0] equals the number of odd LFSR states in the 8-pattern sequence.
REQ-044 res_ready low for 5 cycles during DRAIN -> res_idx and res_count stable throughout; no result lost or duplicated.
REQ-045 abort during the 3rd SETTLE -> IDLE next cycle, no done pulse; the next start yields correct counts from zero.
REQ-046 start pulsed while busy -> ignored, run length unchanged. reset low mid-SAMPLE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/stat_probe_pkg.sv
// Shared definitions for the statistical probe engine: FSM encoding,
// Galois LFSR tap masks indexed by register width, and width helpers.
package stat_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Right-shifting Galois feedback masks for maximal-length sequences.
    // Bit (e-1) is set for every polynomial term x^e other than x^0.
    // Widths 2..32 are covered; other widths fall back to the 4-bit mask.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_000C;
        endcase
    endfunction

    // Ones-counter width: each output bit can be high in at most n_pat patterns.
    function automatic int cnt_width(input int n_pat);
        return $clog2(n_pat + 1);
    endfunction

    // Result index width, never narrower than one bit.
    function automatic int idx_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/stat_probe_lfsr.sv
// Galois LFSR pattern generator with seed load and step enable.
// A zero seed would lock the register, so it is replaced with 1.
module stat_probe_lfsr
    import stat_probe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    input  logic         i_step,
    output logic [W-1:0] o_state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] r_state;
    logic [W-1:0] w_next;

    // One Galois step: shift right, fold the taps in when a one falls out.
    always_comb begin
        w_next = {1'b0, r_state[W-1:1]} ^ (r_state[0] ? TAPS : '0);
    end

    // State register: reset to 1, load (zero-safe) takes priority over step.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ONE;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? ONE : i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/stat_probe_engine.sv
// Statistical probe engine: drives N_PAT pseudo-random patterns plus a
// captured key into a locked circuit, counts ones on every output bit,
// then streams one (index, count) result per output bit.
//
// Result stream: a result transfers on a rising edge where res_valid and
// res_ready are both high; while res_ready is low res_idx/res_count hold.
module stat_probe_engine
    import stat_probe_pkg::*;
#(
    parameter int N_IN       = 32,
    parameter int N_KEY      = 128,
    parameter int N_OUT      = 22,
    parameter int N_PAT      = 256,
    parameter int SETTLE_CYC = 2,
    localparam int CNT_W     = cnt_width(N_PAT),
    localparam int IDX_W     = idx_width(N_OUT)
) (
    input  logic             v_in1_v,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [N_KEY-1:0] key_in,
    input  logic [N_IN-1:0]  seed_in,
    output logic [N_IN-1:0]  dut_in,
    output logic [N_KEY-1:0] dut_key,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic [CNT_W-1:0] res_count,
    output logic             done,
    output logic [2:0]       o_dbg_state
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PAT_LAST    = CNT_W'(N_PAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_OUT - 1);
    localparam logic             NO_SETTLE   = (SETTLE_CYC == 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_KEY-1:0]   r_key;
    logic [CNT_W-1:0]   r_cnt [N_OUT];
    logic [CNT_W-1:0]   r_pat_cnt;
    logic [SET_W-1:0]   r_settle;
    logic [IDX_W-1:0]   r_idx;
    logic [N_IN-1:0]    w_lfsr;
    logic               w_start_acc;
    logic               w_step;

    // Abort beats start even in IDLE, so a simultaneous pair does nothing.
    assign w_start_acc = (r_state == ST_IDLE) && start && !abort;
    assign w_step      = (r_state == ST_SAMPLE) && !abort;

    stat_probe_lfsr #(
        .W (N_IN)
    ) u_lfsr (
        .i_clk   (v_in1_v),
        .i_rst_n (reset),
        .i_load  (w_start_acc),
        .i_seed  (seed_in),
        .i_step  (w_step),
        .o_state (w_lfsr)
    );

    // FSM state register.
    always_ff @(posedge v_in1_v) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) w_state_nxt = ST_APPLY;
                ST_APPLY:  w_state_nxt = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                ST_SETTLE: if (r_settle == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
                ST_SAMPLE: w_state_nxt = (r_pat_cnt == PAT_LAST) ? ST_DRAIN : ST_APPLY;
                ST_DRAIN:  if (res_ready && (r_idx == IDX_LAST)) w_state_nxt = ST_DONE;
                ST_DONE:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: the pattern is only driven while a pattern is in flight,
    // and the result bus is zero outside DRAIN.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        res_valid = (r_state == ST_DRAIN);
        done      = (r_state == ST_DONE);
        dut_in    = '0;
        res_idx   = '0;
        res_count = '0;
        if ((r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) begin
            dut_in = w_lfsr;
        end
        if (r_state == ST_DRAIN) begin
            res_idx   = r_idx;
            res_count = r_cnt[r_idx];
        end
    end

    // Datapath: key capture, settle timer, ones counters, pattern and drain
    // indices. Nothing advances on an abort cycle; counters stay stale.
    always_ff @(posedge v_in1_v) begin
        if (!reset) begin
            r_key     <= '0;
            r_pat_cnt <= '0;
            r_settle  <= '0;
            r_idx     <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_start_acc) begin
            r_key     <= key_in;
            r_pat_cnt <= '0;
            r_settle  <= '0;
            r_idx     <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!abort) begin
            case (r_state)
                ST_APPLY:  r_settle <= '0;
                ST_SETTLE: r_settle <= r_settle + 1'b1;
                ST_SAMPLE: begin
                    r_pat_cnt <= r_pat_cnt + 1'b1;
                    for (int i = 0; i < N_OUT; i++) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(dut_out[i]);
                    end
                end
                ST_DRAIN: begin
                    if (res_ready) begin
                        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_key     = r_key;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stat_probe_engine.sv
// Directed bench for stat_probe_engine (N_IN=4, N_KEY=4, N_OUT=2, N_PAT=8,
// SETTLE_CYC=1). A behavioural model stands in for the circuit under test.
// 4-bit LFSR from seed 1: 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2.
module tb_stat_probe_engine;

    localparam int CNT_W = 4;
    localparam int IDX_W = 1;
    localparam int RES_W = IDX_W + CNT_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [3:0]       key_in;
    logic [3:0]       seed_in;
    logic [3:0]       dut_in;
    logic [3:0]       dut_key;
    logic [1:0]       dut_out;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_idx;
    logic [CNT_W-1:0] res_count;
    logic             done;
    logic [2:0]       dbg_state;

    logic             model_sel;
    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] got_q[$];
    int               n_checks = 0;
    int               n_errors = 0;

    stat_probe_engine #(
        .N_IN       (4),
        .N_KEY      (4),
        .N_OUT      (2),
        .N_PAT      (8),
        .SETTLE_CYC (1)
    ) dut (
        .v_in1_v     (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .key_in      (key_in),
        .seed_in     (seed_in),
        .dut_in      (dut_in),
        .dut_key     (dut_key),
        .dut_out     (dut_out),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_idx     (res_idx),
        .res_count   (res_count),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // Circuit-under-test model: constant {0,1} or {key[0], in[0]}.
    assign dut_out = model_sel ? {dut_key[0], dut_in[0]} : 2'b01;

    // Clock
    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view equals what the
    // next rising edge will see: record every result that will transfer.
    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            got_q.push_back({res_idx, res_count});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] key, input logic [3:0] seed);
        key_in  = key;
        seed_in = seed;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Ticks until done is seen, continuing from a given cycle count.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_item"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic done_seen;

        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        key_in    = 4'h0;
        seed_in   = 4'h0;
        res_ready = 1'b1;
        model_sel = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_dut_key", dut_key, 0);
        chk("rst_res", {res_idx, res_count}, 0);
        reset = 1'b1;
        tick();

        // Constant model, zero seed: counts (0,8),(1,0), done 26 cycles on
        exp_q.push_back({1'b0, 4'd8});
        exp_q.push_back({1'b1, 4'd0});
        do_start(4'hA, 4'h0);
        chk("a_first_dut_in", dut_in, 4'h1);
        chk("a_busy", busy, 1);
        chk("a_key", dut_key, 4'hA);
        repeat (3) tick();
        chk("a_second_dut_in", dut_in, 4'hC);
        wait_done(3, cyc);
        chk("a_done_cycle", cyc, 26);
        tick();
        chk("a_done_pulse", done, 0);
        chk("a_idle_busy", busy, 0);
        chk("a_key_held", dut_key, 4'hA);
        check_stream("a_stream");

        // Key-dependent model with a stalled drain: (0,4),(1,8)
        model_sel = 1'b1;
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 4'd4});
        exp_q.push_back({1'b1, 4'd8});
        do_start(4'h1, 4'h0);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("b_valid_cycle", cyc, 24);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_stall_valid", res_valid, 1);
            chk("b_stall_idx", res_idx, 0);
            chk("b_stall_count", res_count, 4);
        end
        res_ready = 1'b1;
        wait_done(0, cyc);
        tick();
        check_stream("b_stream");

        // Abort in the third SETTLE, then a clean run from seed 7: (0,5),(1,8)
        do_start(4'h1, 4'h0);
        repeat (7) tick();
        chk("c_in_settle", dbg_state, S_SETTLE);
        chk("c_third_pattern", dut_in, 4'h6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_state", dbg_state, S_IDLE);
        chk("c_abort_busy", busy, 0);
        chk("c_abort_valid", res_valid, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            done_seen = done_seen | done;
        end
        chk("c_no_done", done_seen, 0);
        exp_q.push_back({1'b0, 4'd5});
        exp_q.push_back({1'b1, 4'd8});
        do_start(4'h1, 4'h7);
        chk("c_seed7_dut_in", dut_in, 4'h7);
        wait_done(0, cyc);
        tick();
        check_stream("c_stream");

        // Start and abort together in IDLE: nothing happens
        key_in  = 4'h5;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        chk("d_both_busy", busy, 0);
        chk("d_both_key", dut_key, 4'h1);

        // Start while busy is ignored; run length and key unchanged
        model_sel = 1'b0;
        exp_q.push_back({1'b0, 4'd8});
        exp_q.push_back({1'b1, 4'd0});
        do_start(4'h3, 4'h0);
        repeat (4) tick();
        key_in  = 4'hF;
        seed_in = 4'h5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("e_key_kept", dut_key, 4'h3);
        wait_done(5, cyc);
        chk("e_done_cycle", cyc, 26);
        tick();
        check_stream("e_stream");

        // Reset mid-SAMPLE
        model_sel = 1'b1;
        do_start(4'h1, 4'h0);
        repeat (2) tick();
        chk("f_in_sample", dbg_state, S_SAMPLE);
        reset = 1'b0;
        tick();
        chk("f_rst_state", dbg_state, S_IDLE);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_dut_in", dut_in, 0);
        chk("f_rst_dut_key", dut_key, 0);
        chk("f_rst_valid", res_valid, 0);
        chk("f_rst_done", done, 0);
        chk("f_rst_res", {res_idx, res_count}, 0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
